// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile: command/register-file layer sitting behind an SPI slave.
// Each SSEL-framed message is one command byte (RNW + 7-bit start address)
// followed by data bytes that are written to, or read from, a small bank of
// 8-bit registers with address auto-increment. Address 0 returns a constant
// ID, address 1 returns the running message count, the rest are read/write.
module spi_cmd_regfile #(
    parameter int          NREGS  = 8,
    parameter logic [7:0]  ID_VAL = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [7:0]           tx_data,
    output logic [NREGS*8-1:0]   regs_out,
    output logic                 wr_strobe,
    output logic [6:0]           wr_addr,
    output logic [7:0]           err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [7:0] NREGS_B = 8'(NREGS);

    logic [1:0]         state_r;
    logic [6:0]         addr_r;
    logic               rnw_r;
    logic [7:0]         frame_cnt_r;
    logic [7:0]         err_cnt_r;
    logic [7:0]         tx_data_r;
    logic               wr_strobe_r;
    logic [6:0]         wr_addr_r;
    logic [7:0]         regs_r [2:NREGS-1];

    logic               cmd_accept_s;
    logic               data_accept_s;
    logic               in_range_s;
    logic               wr_en_s;
    logic               err_hit_s;
    logic [6:0]         addr_next_s;
    logic [7:0]         tx_next_s;
    logic [NREGS*8-1:0] regs_out_s;

    // Read mux over the flattened bank; addresses at or beyond NREGS read 0x00.
    function automatic logic [7:0] pick(input logic [6:0] a,
                                        input logic [NREGS*8-1:0] bank);
        logic [7:0] val;
        val = 8'h00;
        for (int n = 0; n < NREGS; n++) begin
            val = (a == 7'(n)) ? bank[8*n +: 8] : val;
        end
        return val;
    endfunction

    // Assemble the visible bank: constant ID, live frame count, then RW regs.
    always_comb begin
        regs_out_s        = '0;
        regs_out_s[7:0]   = ID_VAL;
        regs_out_s[15:8]  = frame_cnt_r;
        for (int n = 2; n < NREGS; n++) begin
            regs_out_s[8*n +: 8] = regs_r[n];
        end
    end

    // Decode byte acceptance; a start pulse always drops a coincident byte.
    always_comb begin
        cmd_accept_s  = (state_r == ST_CMD)  && rx_valid && !frame_start;
        data_accept_s = (state_r == ST_DATA) && rx_valid && !frame_start;
        in_range_s    = ({1'b0, addr_r} < NREGS_B);
        wr_en_s       = data_accept_s && !rnw_r && in_range_s && (addr_r >= 7'd2);
        err_hit_s     = data_accept_s && !in_range_s;
        addr_next_s   = addr_r + 7'd1;
    end

    // Next MISO byte: message count at start, otherwise the read-ahead value.
    always_comb begin
        tx_next_s = tx_data_r;
        if (frame_start) begin
            tx_next_s = frame_cnt_r;
        end else if (cmd_accept_s) begin
            tx_next_s = rx_data[7] ? pick(rx_data[6:0], regs_out_s) : 8'h00;
        end else if (data_accept_s) begin
            tx_next_s = rnw_r ? pick(addr_next_s, regs_out_s) : 8'h00;
        end else begin
            tx_next_s = tx_data_r;
        end
    end

    // Message framing FSM; a fresh start re-syncs from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (frame_start) begin
            state_r <= ST_CMD;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_CMD: begin
                    if (frame_end) begin
                        state_r <= ST_IDLE;
                    end else if (rx_valid) begin
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_CMD;
                    end
                end
                ST_DATA: begin
                    if (frame_end) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Command latch and 7-bit auto-incrementing address (wraps at 128).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= 7'd0;
            rnw_r  <= 1'b0;
        end else if (frame_start) begin
            addr_r <= 7'd0;
            rnw_r  <= 1'b0;
        end else if (cmd_accept_s) begin
            addr_r <= rx_data[6:0];
            rnw_r  <= rx_data[7];
        end else if (data_accept_s) begin
            addr_r <= addr_next_s;
        end
    end

    // Message counter: every end-of-frame that closes an active message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 8'h00;
        end else if (frame_end && (state_r != ST_IDLE)) begin
            frame_cnt_r <= frame_cnt_r + 8'h01;
        end
    end

    // Saturating count of data bytes that addressed beyond the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'h00;
        end else if (err_hit_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end
    end

    // Registered MISO byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_r <= 8'h00;
        end else begin
            tx_data_r <= tx_next_s;
        end
    end

    // Write strobe and address, aligned with the register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 7'd0;
        end else begin
            wr_strobe_r <= wr_en_s;
            if (wr_en_s) begin
                wr_addr_r <= addr_r;
            end
        end
    end

    // Writable register storage (addresses 2..NREGS-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 2; n < NREGS; n++) begin
                regs_r[n] <= 8'h00;
            end
        end else begin
            for (int n = 2; n < NREGS; n++) begin
                if (wr_en_s && (addr_r == 7'(n))) begin
                    regs_r[n] <= rx_data;
                end
            end
        end
    end

    assign tx_data   = tx_data_r;
    assign regs_out  = regs_out_s;
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign err_cnt   = err_cnt_r;

endmodule
